// File: rtl/led_counter_checker_pkg.sv
// Shared definitions for the LED counter bus: FSM states, default wrap value
// and the next-value rule, so the counter and the checker agree on the sequence.
package led_counter_checker_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int unsigned DEF_WRAP_MAX = 7;

  function automatic logic [7:0] next_led(input logic [7:0] v, input logic [7:0] wrap_max);
    return (v == wrap_max) ? 8'd0 : v + 8'd1;
  endfunction

endpackage

// File: rtl/led_counter_checker_err_counter.sv
// Saturating error counter; a clear has priority over a simultaneous increment.
module led_err_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/led_counter_checker.sv
// LED counter bus checker: locks onto the 0..WRAP_MAX wrap sequence and counts deviations.
// Optional macro LED_CHECK_CAPTURE_EN adds a capture register for the last bad sample.
module led_counter_checker
  import led_counter_checker_pkg::*;
#(
  parameter int unsigned WRAP_MAX    = DEF_WRAP_MAX,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned UNLOCK_ERRS = 2,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           leds_in,
  input  logic                 sample_en,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [7:0]           expected,
  output logic [7:0]           last_bad
);

  localparam logic [7:0]  WRAP_V  = 8'(WRAP_MAX);
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W  = $clog2(UNLOCK_ERRS + 1);

  state_t             state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [7:0]         exp_q, exp_d;
  logic               pulse_q, pulse_d;
  logic               in_range;
  logic               hit;

  assign in_range = (leds_in <= WRAP_V);
  assign hit      = (leds_in == exp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      match_q <= '0;
      miss_q  <= '0;
      exp_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      exp_q   <= exp_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    miss_d  = miss_q;
    exp_d   = exp_q;
    pulse_d = 1'b0;
    if (sample_en) begin
      case (state_q)
        HUNT: begin
          if (in_range) begin
            exp_d   = next_led(leds_in, WRAP_V);
            match_d = MATCH_W'(1);
            state_d = CONFIRM;
          end
        end
        CONFIRM: begin
          if (hit) begin
            exp_d = next_led(exp_q, WRAP_V);
            if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
              match_d = '0;
              state_d = LOCKED;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else if (in_range) begin
            exp_d   = next_led(leds_in, WRAP_V);
            match_d = MATCH_W'(1);
          end else begin
            match_d = '0;
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: expected advances on every sample, good or bad.
          exp_d = next_led(exp_q, WRAP_V);
          if (hit) begin
            miss_d = '0;
          end else begin
            pulse_d = 1'b1;
            if (miss_q == MISS_W'(UNLOCK_ERRS - 1)) begin
              miss_d  = '0;
              state_d = HUNT;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  led_err_counter #(.W(ERR_CNT_W)) u_err_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pulse_d),
    .clr   (clr_err),
    .count (err_count)
  );

  assign locked    = (state_q == LOCKED);
  assign err_pulse = pulse_q;
  assign expected  = exp_q;

`ifdef LED_CHECK_CAPTURE_EN
  logic [7:0] last_bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_bad_q <= '0;
    end else if (pulse_d) begin
      last_bad_q <= leds_in;
    end
  end

  assign last_bad = last_bad_q;
`else
  assign last_bad = '0;
`endif

endmodule
